// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Runs on the base clock; the core pops one byte per ',' instruction.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             uart_rx,
  input  logic                             rd_en,
  output logic [7:0]                       rd_data,
  output logic                             rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  output logic                             frame_err,
  output logic                             overrun_err,
  input  logic                             err_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rxs_q;
  logic [15:0]   timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          timer_done;
  logic          push_req, frame_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_err_q, overrun_err_d;
  logic          pop, push_ok, overrun_set;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rxs_q   <= sync1_q;
    end
  end

  assign timer_done = (timer_q == 16'd0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_done ? timer_q : timer_q - 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          timer_d = HALF_RELOAD;
        end
      end
      S_START: begin
        if (timer_done) begin
          if (!rxs_q) begin
            state_d   = S_DATA;
            timer_d   = BIT_RELOAD;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer_done) begin
          shift_d[bit_idx_q] = rxs_q;
          timer_d            = BIT_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        // Returning to IDLE at mid-stop leaves half a bit of slack for a fast sender.
        if (timer_done) begin
          if (rxs_q) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // A full FIFO still accepts a push when the same cycle pops.
  assign pop         = rd_en && (count_q != '0);
  assign push_ok     = push_req && ((count_q != CW'(FIFO_DEPTH)) || pop);
  assign overrun_set = push_req && !push_ok;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);

    frame_err_d   = err_clr ? 1'b0 : frame_err_q;
    overrun_err_d = err_clr ? 1'b0 : overrun_err_q;
    if (frame_set)   frame_err_d   = 1'b1;
    if (overrun_set) overrun_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign rd_valid    = (count_q != '0);
  assign count       = count_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=16, FIFO_DEPTH=4.
// All bench actions happen 1 ns after a rising clock edge.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB     = 16;
  localparam int DEPTH   = 4;
  localparam int BIT_NS  = 160;
  localparam int FAST_NS = 155;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun_err;

  int vec_count = 0;
  int err_count = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, LSB first; the line is left at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int bit_ns);
    uart_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      #(bit_ns);
    end
    uart_rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic popByte(input string tag, input logic [7:0] expected);
    checkOutput({tag, "_valid"}, 16'(rd_valid), 16'd1);
    checkOutput({tag, "_data"}, 16'(rd_data), 16'(expected));
    rd_en = 1'b1;
    waitCycles(1);
    rd_en = 1'b0;
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    waitCycles(1);
    err_clr = 1'b0;
  endtask

  task automatic checkFlags(input string tag, input logic fe, input logic oe);
    checkOutput({tag, "_frame_err"}, 16'(frame_err), 16'(fe));
    checkOutput({tag, "_overrun_err"}, 16'(overrun_err), 16'(oe));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] seq2 [4];
    seq2[0] = 8'h00; seq2[1] = 8'hFF; seq2[2] = 8'h55; seq2[3] = 8'h3C;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 16'(rd_valid), 16'd0);
    checkOutput("rst_count", 16'(count), 16'd0);
    checkFlags("rst", 1'b0, 1'b0);
    rst = 1'b0;
    waitCycles(4);
    checkOutput("post_rst_count", 16'(count), 16'd0);

    // Single byte: the push lands on the edge ending cycle 155 after the start edge.
    fork
      applyStimulus(8'hA5, 1'b1, BIT_NS);
      begin
        waitCycles(154);
        checkOutput("t1_valid_before_stop", 16'(rd_valid), 16'd0);
        waitCycles(1);
        checkOutput("t1_valid_after_stop", 16'(rd_valid), 16'd1);
      end
    join
    checkOutput("t1_data", 16'(rd_data), 16'h00A5);
    checkOutput("t1_count", 16'(count), 16'd1);
    rd_en = 1'b1;
    waitCycles(1);
    rd_en = 1'b0;
    checkOutput("t1_valid_popped", 16'(rd_valid), 16'd0);
    checkOutput("t1_count_popped", 16'(count), 16'd0);

    // Back-to-back with a 3% fast sender.
    for (int i = 0; i < 4; i++) applyStimulus(seq2[i], 1'b1, FAST_NS);
    waitCycles(5);
    checkOutput("t2_count", 16'(count), 16'd4);
    checkFlags("t2", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) popByte("t2_pop", seq2[i]);
    checkOutput("t2_count_empty", 16'(count), 16'd0);

    // Overrun: fifth byte is dropped.
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1, BIT_NS);
    waitCycles(2);
    checkOutput("t3_count_full", 16'(count), 16'd4);
    checkFlags("t3_full", 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b1, BIT_NS);
    waitCycles(2);
    checkOutput("t3_count_overrun", 16'(count), 16'd4);
    checkFlags("t3_overrun", 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) popByte("t3_pop", 8'(i));
    checkOutput("t3_valid_empty", 16'(rd_valid), 16'd0);
    pulseErrClr();
    checkFlags("t3_cleared", 1'b0, 1'b0);

    // Framing error followed by a held-low line.
    applyStimulus(8'h81, 1'b0, BIT_NS);
    waitCycles(10);
    checkFlags("t4_frame", 1'b1, 1'b0);
    checkOutput("t4_count", 16'(count), 16'd0);
    pulseErrClr();
    waitCycles(300);
    checkFlags("t4_break_held", 1'b0, 1'b0);
    checkOutput("t4_break_count", 16'(count), 16'd0);
    uart_rx = 1'b1;
    waitCycles(40);
    checkOutput("t4_after_break_count", 16'(count), 16'd0);
    uart_rx = 1'b0;
    waitCycles(4);
    uart_rx = 1'b1;
    waitCycles(40);
    checkOutput("t4_glitch_count", 16'(count), 16'd0);
    checkFlags("t4_glitch", 1'b0, 1'b0);

    // Boundaries: simultaneous push and pop while full, then a read while empty.
    applyStimulus(8'h11, 1'b1, BIT_NS);
    applyStimulus(8'h22, 1'b1, BIT_NS);
    applyStimulus(8'h33, 1'b1, BIT_NS);
    applyStimulus(8'h44, 1'b1, BIT_NS);
    waitCycles(2);
    checkOutput("t5_count_full", 16'(count), 16'd4);
    fork
      applyStimulus(8'h55, 1'b1, BIT_NS);
      begin
        waitCycles(154);
        rd_en = 1'b1;
        waitCycles(1);
        rd_en = 1'b0;
        checkOutput("t5_count_pushpop", 16'(count), 16'd4);
        checkFlags("t5_pushpop", 1'b0, 1'b0);
      end
    join
    popByte("t5_pop", 8'h22);
    popByte("t5_pop", 8'h33);
    popByte("t5_pop", 8'h44);
    popByte("t5_pop", 8'h55);
    rd_en = 1'b1;
    waitCycles(3);
    rd_en = 1'b0;
    checkOutput("t5_empty_read_count", 16'(count), 16'd0);
    checkOutput("t5_empty_read_valid", 16'(rd_valid), 16'd0);
    checkFlags("t5_empty_read", 1'b0, 1'b0);
    applyStimulus(8'h66, 1'b1, BIT_NS);
    waitCycles(2);
    checkOutput("t5_after_empty_count", 16'(count), 16'd1);
    popByte("t5_after_empty", 8'h66);

    // Reset during bit 4 of 0x7E with two bytes queued.
    applyStimulus(8'h10, 1'b1, BIT_NS);
    applyStimulus(8'h20, 1'b1, BIT_NS);
    waitCycles(2);
    checkOutput("t6_count_queued", 16'(count), 16'd2);
    fork
      applyStimulus(8'h7E, 1'b1, BIT_NS);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_count", 16'(count), 16'd0);
        checkOutput("t6_rst_valid", 16'(rd_valid), 16'd0);
        checkFlags("t6_rst", 1'b0, 1'b0);
      end
    join
    waitCycles(2);
    rst = 1'b0;
    waitCycles(4);
    checkOutput("t6_post_rst_count", 16'(count), 16'd0);
    applyStimulus(8'h42, 1'b1, BIT_NS);
    waitCycles(2);
    checkOutput("t6_new_count", 16'(count), 16'd1);
    popByte("t6_new", 8'h42);
    checkFlags("t6_end", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with a first-word-fall-through receive FIFO. It supplies input bytes to the Brainfuck core for the `,` instruction, complementing the transmit path inside the SFR block. It sits on the 50 MHz base clock, not the divided core clock. The core side pops one byte per `,`; the line side runs 8N1, LSB first.

## Interface
- `CLKS_PER_BIT`, default 434: base-clock cycles per UART bit (50 MHz / 115200); legal range 8..65535.
- `FIFO_DEPTH`, default 16: receive FIFO entries; power of two, 2..256.
- `clk` in 1: base clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `uart_rx` in 1: asynchronous serial line; idles high.
- `rd_en` in 1: pop request; acts only while `rd_valid`=1.
- `rd_data` out 8: FIFO head byte; valid while `rd_valid`=1.
- `rd_valid` out 1: FIFO not empty.
- `count` out $clog2(FIFO_DEPTH+1): number of bytes held.
- `frame_err` out 1: sticky; a stop bit was sampled low.
- `overrun_err` out 1: sticky; a byte was dropped because the FIFO was full.
- `err_clr` in 1: synchronous clear of both sticky flags.

## Operation
- **Synchronizer:** `uart_rx` passes through 2 flops before any use (`rxs`). Both flops reset to 1.
- **Bit timer:** a down-counter reloads to CLKS_PER_BIT-1. Bit index runs 0..7.
- **State: IDLE.** When `rxs`=0, load timer with CLKS_PER_BIT/2-1 (integer division) and go to START.
- **State: START.** When the timer expires, sample `rxs`.
  - 0: reload the timer and go to DATA with bit index 0.
  - 1: glitch; return to IDLE. Nothing is pushed and no flag is set.
- **State: DATA.** On each timer expiry, shift `rxs` into bit[index], LSB first. After bit 7, go to STOP.
- **State: STOP.** When the timer expires, sample `rxs`.
  - 1: push the byte and go to IDLE.
  - 0: set `frame_err`, discard the byte, and go to BREAK.
- **State: BREAK.** Wait for `rxs`=1, then go to IDLE. A held-low line therefore yields exactly one frame error and no bytes.
- **FIFO:** circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus a separate `count` register.
  - `rd_data` = mem[rd_ptr], combinational read, first-word fall-through.
  - Pop: `rd_en` & `rd_valid`.
  - Push: a good stop bit, accepted when `count` < FIFO_DEPTH or a pop occurs in the same cycle.
  - Push while full with no pop: the byte is dropped, `overrun_err` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both take effect and `count` is unchanged, including when full (no overrun).
  - `rd_en` while empty: ignored; no pointer movement and no error.
- **Error flags:** `err_clr` clears both flags. If a set event and `err_clr` occur in the same cycle, set wins.
- **Reset values:** state IDLE, FIFO empty, `rd_valid`=0, `count`=0, `frame_err`=0, `overrun_err`=0. `rd_data` is don't-care while `rd_valid`=0; memory is not reset.

## Timing
- The `uart_rx` falling edge reaches `rxs` 2 cycles later (±1 for asynchronous phase).
- Start-bit check: CLKS_PER_BIT/2 cycles after IDLE sees `rxs`=0.
- Data bit k is sampled CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT cycles after the start is detected. The stop bit is sampled at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- The push is registered in the stop-sample cycle. `rd_valid`, `count`, and `rd_data` update on the following edge.
- Pop: pointer and `count` update on the edge where `rd_en`&`rd_valid`. The next head appears the following cycle, or `rd_valid` falls if the FIFO is now empty.
- After a good stop, the block returns to IDLE at mid-stop-bit, so back-to-back frames are received with ±4% baud mismatch.
- Sticky flags set on the edge after the triggering sample or push attempt.
- Reset mid-frame discards the partial byte and all FIFO contents. After deassertion, a line that is already low is treated as a start bit.

## Test plan
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
1. **Single byte:** send 0xA5 framed 8N1 → `rd_valid` rises 1 cycle after the mid-stop sample, `rd_data`=0xA5, `count`=1. Pulse `rd_en` → `rd_valid`=0 and `count`=0 on the next edge.
2. **Back-to-back and order:** send 0x00, 0xFF, 0x55, 0x3C with no idle gap and a transmitter 3% fast → pops return them in that order with no flags set.
3. **Overrun:** send 5 bytes 0x01..0x05 with no reads → `count`=4, `overrun_err`=1, pops return 0x01..0x04. Then `err_clr` → flag 0.
4. **Framing and glitch:** send 0x81 with the stop bit low → nothing pushed, `frame_err`=1, and BREAK is held until the line goes high. Then a 4-cycle low glitch → no push and no flag.
5. **Boundaries:** with the FIFO full, pop and push in the same cycle → `count` stays 4, no overrun, wrapped order correct. `rd_en` while empty → no change.
6. **Reset:** assert `rst` during bit 4 of 0x7E while 2 bytes are queued → all outputs 0 immediately. The next clean 0x42 is received correctly.
